// File: rtl/fft_uart_pkg.sv
// Shared encodings for the FFT result frame sender.
// State and phase enums plus the default frame header byte.
package fft_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        KICK,
        WAIT_TX,
        GAP,
        FETCH,
        LATCH,
        FIN
    } state_t;

    typedef enum logic [1:0] {
        HDR,
        DATA,
        CHK
    } phase_t;

    localparam logic [7:0] DEF_HEADER = 8'hA5;

endpackage

// File: rtl/fft_uart_sender.sv
// Streams one FFT result frame (header, LS-first payload, XOR checksum)
// to a byte-wide UART transmitter with a per-byte watchdog.
module fft_uart_sender
    import fft_uart_pkg::*;
#(
    parameter int         N_WORDS     = 16,
    parameter int         WORD_W      = 16,
    parameter int         ADDR_W      = 4,
    parameter logic [7:0] HEADER      = DEF_HEADER,
    parameter int         TIMEOUT_CYC = 1024
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [WORD_W-1:0] i_rd_data,
    output logic              o_tx_start,
    output logic [7:0]        o_tx_byte,
    input  logic              i_tx_busy,
    input  logic              i_tx_done
);

    localparam int BYTES = WORD_W / 8;
    localparam int BI_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int WI_W  = ADDR_W + 1;

    state_t            state, state_d;
    phase_t            phase, phase_d;
    logic [7:0]        csum, csum_d;
    logic [WI_W-1:0]   word_idx, word_idx_d;
    logic [BI_W-1:0]   byte_idx, byte_idx_d;
    logic [WD_W-1:0]   wd, wd_d;
    logic [WORD_W-1:0] shreg, shreg_d;
    logic [WORD_W-1:0] shifted;

    logic              busy_d, done_d, error_d, rd_en_d, tx_start_d;
    logic [ADDR_W-1:0] rd_addr_d;
    logic [7:0]        tx_byte_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            phase      <= HDR;
            csum       <= '0;
            word_idx   <= '0;
            byte_idx   <= '0;
            wd         <= '0;
            shreg      <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_error    <= 1'b0;
            o_rd_en    <= 1'b0;
            o_rd_addr  <= '0;
            o_tx_start <= 1'b0;
            o_tx_byte  <= '0;
        end else begin
            state      <= state_d;
            phase      <= phase_d;
            csum       <= csum_d;
            word_idx   <= word_idx_d;
            byte_idx   <= byte_idx_d;
            wd         <= wd_d;
            shreg      <= shreg_d;
            o_busy     <= busy_d;
            o_done     <= done_d;
            o_error    <= error_d;
            o_rd_en    <= rd_en_d;
            o_rd_addr  <= rd_addr_d;
            o_tx_start <= tx_start_d;
            o_tx_byte  <= tx_byte_d;
        end
    end

    always_comb begin
        state_d    = state;
        phase_d    = phase;
        csum_d     = csum;
        word_idx_d = word_idx;
        byte_idx_d = byte_idx;
        wd_d       = wd;
        shreg_d    = shreg;
        busy_d     = o_busy;
        done_d     = 1'b0;
        error_d    = 1'b0;
        rd_en_d    = 1'b0;
        rd_addr_d  = o_rd_addr;
        tx_start_d = 1'b0;
        tx_byte_d  = o_tx_byte;
        shifted    = shreg >> 8;

        unique case (state)
            IDLE: begin
                if (i_start) begin
                    tx_byte_d  = HEADER;
                    csum_d     = '0;
                    word_idx_d = '0;
                    byte_idx_d = '0;
                    phase_d    = HDR;
                    busy_d     = 1'b1;
                    state_d    = KICK;
                end
            end
            KICK: begin
                tx_start_d = 1'b1;
                if (phase == DATA) csum_d = csum ^ o_tx_byte;
                wd_d    = '0;
                state_d = WAIT_TX;
            end
            WAIT_TX: begin
                if (i_tx_done) begin
                    state_d = GAP;
                end else if (wd == WD_W'(TIMEOUT_CYC - 1)) begin
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    wd_d = wd + WD_W'(1);
                end
            end
            GAP: begin
                // Pick the next byte source; a finished word goes back to memory.
                if (phase == CHK) begin
                    state_d = FIN;
                end else if (phase == DATA && byte_idx != BI_W'(BYTES - 1)) begin
                    byte_idx_d = byte_idx + BI_W'(1);
                    shreg_d    = shifted;
                    tx_byte_d  = shifted[7:0];
                    state_d    = KICK;
                end else if (phase == DATA && word_idx == WI_W'(N_WORDS)) begin
                    tx_byte_d = csum;
                    phase_d   = CHK;
                    state_d   = KICK;
                end else begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = word_idx[ADDR_W-1:0];
                    state_d   = FETCH;
                end
            end
            FETCH: begin
                state_d = LATCH;
            end
            LATCH: begin
                shreg_d    = i_rd_data;
                tx_byte_d  = i_rd_data[7:0];
                byte_idx_d = '0;
                word_idx_d = word_idx + WI_W'(1);
                phase_d    = DATA;
                state_d    = KICK;
            end
            FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The UART must report busy once a byte is in flight.
    a_tx_busy: assert property (
        @(posedge i_clk) disable iff (!i_rst_n)
        (state == WAIT_TX && wd != '0) |-> i_tx_busy
    );

endmodule

// File: tb/tb_fft_uart_sender.sv
// Directed bench for fft_uart_sender with a UART TX model and a
// 1-cycle-latency result memory model.
module tb_fft_uart_sender;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic        i_start;
    logic        o_busy, o_done, o_error, o_rd_en;
    logic [3:0]  o_rd_addr;
    logic [15:0] i_rd_data;
    logic        o_tx_start;
    logic [7:0]  o_tx_byte;
    logic        i_tx_busy, i_tx_done;

    always #5 clk = ~clk;

    fft_uart_sender #(
        .TIMEOUT_CYC(32)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (i_rst_n),
        .i_start   (i_start),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_error   (o_error),
        .o_rd_en   (o_rd_en),
        .o_rd_addr (o_rd_addr),
        .i_rd_data (i_rd_data),
        .o_tx_start(o_tx_start),
        .o_tx_byte (o_tx_byte),
        .i_tx_busy (i_tx_busy),
        .i_tx_done (i_tx_done)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [16];
    logic [15:0] pend;
    logic        pend_v = 1'b0;
    bit          hang = 1'b0;
    int          tx_cnt = 0;
    logic [7:0]  cur_byte;
    logic        rd_en_prev = 1'b0;
    logic        start_prev = 1'b0;
    int          cyc = 0;
    int          start_cyc, first_start_cyc, last_evt, done_at, err_cyc;
    int          done_cnt, err_cnt, rd_en_long, start_long;
    int          byte_q[$];
    int          addr_q[$];

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        i_rd_data = pend_v ? pend : 16'hDEAD;
        pend_v    = o_rd_en;
        if (o_rd_en) begin
            pend = mem[o_rd_addr];
            addr_q.push_back(int'(o_rd_addr));
            if (rd_en_prev) rd_en_long++;
            chk("gap_rd", cyc - done_at, 2);
            last_evt = cyc;
        end
        rd_en_prev = o_rd_en;
        if (i_tx_done) begin
            i_tx_done = 1'b0;
            i_tx_busy = 1'b0;
        end
        if (o_tx_start) begin
            if (start_prev) start_long++;
            if (byte_q.size() == 0) begin
                chk("hdr_lat", cyc - start_cyc, 2);
                first_start_cyc = cyc;
            end else begin
                chk("gap_start", cyc - last_evt, 3);
            end
            byte_q.push_back(int'(o_tx_byte));
            cur_byte  = o_tx_byte;
            i_tx_busy = 1'b1;
            tx_cnt    = hang ? 0 : 3;
        end else if (tx_cnt > 0) begin
            tx_cnt--;
            if (tx_cnt == 0) begin
                chk("tx_byte_stable", int'(o_tx_byte), int'(cur_byte));
                i_tx_done = 1'b1;
                done_at   = cyc;
                last_evt  = cyc;
            end
        end
        start_prev = o_tx_start;
        if (o_done) done_cnt++;
        if (o_error) begin
            err_cnt++;
            err_cyc = cyc;
        end
    endtask

    task automatic clear_mon();
        byte_q.delete();
        addr_q.delete();
        done_cnt   = 0;
        err_cnt    = 0;
        rd_en_long = 0;
        start_long = 0;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_busy"}, int'(o_busy), 0);
        chk({tag, "_done"}, int'(o_done), 0);
        chk({tag, "_error"}, int'(o_error), 0);
        chk({tag, "_rd_en"}, int'(o_rd_en), 0);
        chk({tag, "_rd_addr"}, int'(o_rd_addr), 0);
        chk({tag, "_tx_start"}, int'(o_tx_start), 0);
        chk({tag, "_tx_byte"}, int'(o_tx_byte), 0);
    endtask

    task automatic run_frame(input string tag, input int csum, input bit dbl);
        int exp_b, got_b, w, b;
        clear_mon();
        i_start   = 1'b1;
        start_cyc = cyc;
        tick();
        i_start = 1'b0;
        chk({tag, "_busy_on"}, int'(o_busy), 1);
        for (int n = 0; n < 3000 && done_cnt == 0 && err_cnt == 0; n++) begin
            tick();
            i_start = (dbl && cyc == start_cyc + 40) ? 1'b1 : 1'b0;
        end
        i_start = 1'b0;
        chk({tag, "_finished"}, done_cnt, 1);
        repeat (8) tick();
        chk({tag, "_done_cnt"}, done_cnt, 1);
        chk({tag, "_err_cnt"}, err_cnt, 0);
        chk({tag, "_busy_off"}, int'(o_busy), 0);
        chk({tag, "_nbytes"}, byte_q.size(), 34);
        chk({tag, "_rd_en_width"}, rd_en_long, 0);
        chk({tag, "_start_width"}, start_long, 0);
        chk({tag, "_naddr"}, addr_q.size(), 16);
        for (int i = 0; i < 34; i++) begin
            if (i == 0) begin
                exp_b = 'hA5;
            end else if (i == 33) begin
                exp_b = csum;
            end else begin
                w     = (i - 1) / 2;
                b     = (i - 1) % 2;
                exp_b = int'(mem[w][8*b +: 8]);
            end
            got_b = (i < byte_q.size()) ? byte_q[i] : 'h100;
            chk($sformatf("%s_byte%0d", tag, i), got_b, exp_b);
        end
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("%s_addr%0d", tag, i),
                (i < addr_q.size()) ? addr_q[i] : 'h100, i);
        end
    endtask

    initial begin
        i_rst_n   = 1'b0;
        i_start   = 1'b0;
        i_tx_busy = 1'b0;
        i_tx_done = 1'b0;
        i_rd_data = '0;
        done_at   = 0;
        last_evt  = 0;
        start_cyc = 0;
        err_cyc   = 0;
        first_start_cyc = 0;
        clear_mon();
        for (int i = 0; i < 16; i++) mem[i] = '0;
        repeat (3) tick();
        chk_reset_outs("rst");
        i_rst_n = 1'b1;
        tick();

        mem[0] = 16'h1234;
        run_frame("basic", 'h26, 1'b0);

        for (int i = 0; i < 16; i++) mem[i] = 16'(16'h0101 * i);
        run_frame("ramp", 'h00, 1'b0);

        run_frame("dbl", 'h00, 1'b1);
        run_frame("after_dbl", 'h00, 1'b0);

        for (int i = 0; i < 16; i++) mem[i] = '0;
        mem[3] = 16'hBEEF;
        clear_mon();
        i_start   = 1'b1;
        start_cyc = cyc;
        tick();
        i_start = 1'b0;
        for (int n = 0; n < 2000 && byte_q.size() < 11; n++) tick();
        chk("midrst_reached", byte_q.size(), 11);
        i_rst_n = 1'b0;
        #1;
        chk_reset_outs("midrst");
        tx_cnt    = 0;
        i_tx_done = 1'b0;
        i_tx_busy = 1'b0;
        pend_v    = 1'b0;
        repeat (3) tick();
        i_rst_n = 1'b1;
        repeat (2) tick();
        chk("midrst_no_done", done_cnt, 0);
        chk("midrst_no_err", err_cnt, 0);
        run_frame("post_rst", 'h51, 1'b0);

        hang = 1'b1;
        clear_mon();
        i_start   = 1'b1;
        start_cyc = cyc;
        tick();
        i_start = 1'b0;
        for (int n = 0; n < 200 && err_cnt == 0; n++) tick();
        chk("wd_fired", err_cnt, 1);
        chk("wd_delay", err_cyc - first_start_cyc, 32);
        repeat (5) tick();
        chk("wd_err_pulse", err_cnt, 1);
        chk("wd_no_done", done_cnt, 0);
        chk("wd_busy_off", int'(o_busy), 0);
        chk("wd_nbytes", byte_q.size(), 1);
        hang      = 1'b0;
        i_tx_busy = 1'b0;
        tick();

        mem[0] = 16'h1234;
        mem[3] = 16'h0000;
        run_frame("post_wd", 'h26, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_uart_sender.md
Name: fft_uart_sender

Overview:
Frame scheduler that streams one FFT result frame over the byte-wide UART transmitter. On request it reads N_WORDS result words from the FFT result memory through a 1-cycle-latency read port. It serialises the frame as header, payload bytes (LS byte first) and an XOR checksum. Each byte is handed to the UART TX through its start/done handshake, with a per-byte watchdog.

Parameters:
N_WORDS, 16, words per frame
WORD_W, 16, result word width; must be a multiple of 8 (BYTES = WORD_W/8)
ADDR_W, 4, result memory address width; 2**ADDR_W >= N_WORDS
HEADER, 8'hA5, first byte of every frame
TIMEOUT_CYC, 1024, max cycles allowed in WAIT_TX before abort

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_start  in  1  frame request; sampled only in IDLE
o_busy  out  1  high from the cycle after an accepted i_start until return to IDLE
o_done  out  1  1-cycle pulse: frame fully sent
o_error  out  1  1-cycle pulse: watchdog abort
o_rd_en  out  1  result memory read strobe
o_rd_addr  out  ADDR_W  word index being read
i_rd_data  in  WORD_W  read data, valid the cycle after o_rd_en
o_tx_start  out  1  1-cycle start pulse to UART TX
o_tx_byte  out  8  byte to send; stable from o_tx_start until i_tx_done
i_tx_busy  in  1  UART transfer-in-progress flag (status only)
i_tx_done  in  1  UART 1-cycle byte-complete pulse

Behaviour:
- Reset (async, i_rst_n=0): state=IDLE. o_busy, o_done, o_error, o_rd_en, o_tx_start = 0. o_rd_addr=0, o_tx_byte=0. Checksum, word/byte indices and watchdog = 0. A reset mid-frame abandons the frame silently, with no o_done and no o_error.
- All outputs are registered.
- States:
  - IDLE: i_start=1 → load o_tx_byte=HEADER, clear checksum and indices, phase=HDR → KICK.
  - KICK: o_tx_start=1 for exactly one cycle. For data bytes, checksum ^= o_tx_byte. → WAIT_TX.
  - WAIT_TX: i_tx_done=1 → GAP. Otherwise the watchdog increments. When the watchdog reaches TIMEOUT_CYC-1, pulse o_error → IDLE (abort). The watchdog clears on entry to WAIT_TX.
  - GAP: exactly one idle cycle, so the UART can return to idle. Next state:
    - phase HDR, or last byte of a word with more words left → FETCH.
    - Mid-word → o_tx_byte = next byte of the word shift register → KICK.
    - Last byte of the last word → o_tx_byte = checksum, phase=CHK → KICK.
    - phase CHK → FIN.
  - FETCH: o_rd_en=1, o_rd_addr=word index → LATCH.
  - LATCH: capture i_rd_data into the shift register, o_tx_byte = bits[7:0], byte index=0, word index+1, phase=DATA → KICK.
  - FIN: o_done=1 for one cycle → IDLE.
- Latency: i_start in cycle 0 → o_tx_start in cycle 2 (IDLE registers the header in cycle 1; KICK drives the pulse).
- Frame length is 2 + N_WORDS*BYTES bytes (34 at defaults). Word order is ascending addresses; byte order within a word is LS byte first.
- Checksum is the XOR of payload bytes only; header and checksum bytes are excluded.
- i_start while o_busy=1 is ignored, not queued.
- i_tx_done outside WAIT_TX is ignored.
- i_tx_busy does not gate sequencing. It is used only as an assertion check: it must be 1 during WAIT_TX after the first cycle.
- Word index does not wrap; the frame ends after index N_WORDS-1.

Decomposition:
- Package fft_uart_pkg: state encoding constants (IDLE, KICK, WAIT_TX, GAP, FETCH, LATCH, FIN), phase constants (HDR, DATA, CHK), default HEADER value.
- No sub-module. The watchdog counter and byte serializer stay inline.
- A top-level wrapper instantiates this block next to the existing UART transmitter with CLOCK_PER_BIT unchanged.

Test Plan:
- Basic frame: memory word0=16'h1234, others 0; pulse i_start with the real UART TX plus a UART RX model → bytes A5, 34, 12, then 30 × 00, then 26; one o_done pulse; o_error never asserted.
- Ramp frame: word i = 16'h0101*i → payload lo=hi=i, checksum 00, 34 bytes total; o_rd_addr sequence 0..15, each o_rd_en a single cycle.
- Watchdog: UART stub that never pulses i_tx_done, TIMEOUT_CYC=32 → o_error pulses exactly 32 cycles after the header KICK; block returns to IDLE; no o_done.
- Start while busy: second i_start pulse mid-frame → frame identical to a single request; exactly one o_done; a subsequent i_start after o_done starts a new frame.
- Reset mid-frame: assert i_rst_n=0 during byte 10 → all outputs at reset values immediately; after release, a new i_start produces a complete correct frame.
- Handshake timing: check o_tx_start is high for one cycle only; o_tx_byte is stable from o_tx_start until i_tx_done; exactly one GAP cycle between i_tx_done and the next o_tx_start or o_rd_en.
